inst_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the decode/execute stage of the 2-stage pipelined MIPS core.
- Owns the PC and issues one-at-a-time requests to a variable-latency instruction memory.
- Registers the fetched word plus its PC into the IF/ID output register that drives the decoder's inst input.
- Applies taken-branch and jump redirects resolved by the consumer stage. No delay slot: any wrong-path word is squashed.

---
 rtl/inst_fetch_unit_pkg.sv | 20 ++
 rtl/inst_fetch_unit_next_pc_calc.sv | 40 ++++
 rtl/inst_fetch_unit.sv | 133 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the decoder of the 2-stage MIPS core.
package inst_fetch_unit_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } fetch_state_e;

  // sll $0,$0,0 -- harmless filler whenever no real instruction is presented.
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Primary opcodes of the jump instructions.
  localparam logic [5:0] OPC_J   = 6'h02;
  localparam logic [5:0] OPC_JAL = 6'h03;

endpackage

// File: rtl/inst_fetch_unit_next_pc_calc.sv
// Next-PC arithmetic: sequential increment plus branch/jump redirect selection.
module inst_fetch_unit_next_pc_calc (
  input  logic [31:0] fetch_pc_i,
  input  logic [31:0] cur_pc_plus4_i,
  input  logic        redirect_en_i,
  input  logic        branch_taken_i,
  input  logic [15:0] beq_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_offset_i,
  output logic [31:0] fetch_pc_plus4_o,
  output logic        redirect_o,
  output logic [31:0] redirect_target_o
);

  logic [31:0] branch_disp;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign fetch_pc_plus4_o = fetch_pc_i + 32'd4;
  // Word offset, sign-extended and scaled to bytes.
  assign branch_disp      = {{14{beq_offset_i[15]}}, beq_offset_i, 2'b00};
  assign branch_target    = cur_pc_plus4_i + branch_disp;
  assign jump_target      = {cur_pc_plus4_i[31:28], jump_offset_i, 2'b00};

  // Jump beats branch when the consumer flags both.
  always_comb begin
    redirect_o        = 1'b0;
    redirect_target_o = branch_target;
    if (redirect_en_i) begin
      if (jump_i) begin
        redirect_o        = 1'b1;
        redirect_target_o = jump_target;
      end else if (branch_taken_i) begin
        redirect_o        = 1'b1;
        redirect_target_o = branch_target;
      end
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests and fills
// the IF/ID register feeding the decoder. Redirects squash wrong-path words.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall_in,
  input  logic        branch_taken,
  input  logic [15:0] beq_offset,
  input  logic        jump,
  input  logic [25:0] jump_offset,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         kill_q;
  logic [31:0]  out_inst_q;
  logic [31:0]  out_pc_q;
  logic         out_valid_q;
  logic [31:0]  hold_inst_q;
  logic [31:0]  hold_pc_q;

  logic         consume;
  logic         redirect;
  logic [31:0]  redirect_target;
  logic [31:0]  pc_plus4;
  logic [31:0]  cur_pc_plus4;

  assign consume      = out_valid_q & ~stall_in;
  assign cur_pc_plus4 = out_pc_q + 32'd4;

  inst_fetch_unit_next_pc_calc u_next_pc_calc (
    .fetch_pc_i        (pc_q),
    .cur_pc_plus4_i    (cur_pc_plus4),
    .redirect_en_i     (consume),
    .branch_taken_i    (branch_taken),
    .beq_offset_i      (beq_offset),
    .jump_i            (jump),
    .jump_offset_i     (jump_offset),
    .fetch_pc_plus4_o  (pc_plus4),
    .redirect_o        (redirect),
    .redirect_target_o (redirect_target)
  );

  // Fetch sequencer together with PC, kill flag, hold buffer and IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      out_inst_q  <= NOP_INST;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
      hold_inst_q <= NOP_INST;
      hold_pc_q   <= '0;
    end else begin
      // A consumed slot empties unless something refills it below.
      if (consume) begin
        out_valid_q <= 1'b0;
        out_inst_q  <= NOP_INST;
      end
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          state_q <= StWait;
          // The request just issued is now wrong-path; drop its response.
          if (redirect) begin
            pc_q   <= redirect_target;
            kill_q <= 1'b1;
          end
        end
        StWait: begin
          if (imem_valid) begin
            state_q <= StReq;
            if (kill_q) begin
              kill_q <= 1'b0;
            end else if (redirect) begin
              // Slot is free but the arriving word follows a redirected instruction.
              pc_q <= redirect_target;
            end else if (!out_valid_q || !stall_in) begin
              out_inst_q  <= imem_rdata;
              out_pc_q    <= pc_q;
              out_valid_q <= 1'b1;
              pc_q        <= pc_plus4;
            end else begin
              hold_inst_q <= imem_rdata;
              hold_pc_q   <= pc_q;
              pc_q        <= pc_plus4;
              state_q     <= StHold;
            end
          end else if (redirect) begin
            pc_q   <= redirect_target;
            kill_q <= 1'b1;
          end
        end
        StHold: begin
          // Output is always valid here, so stall release means it is consumed.
          if (!stall_in) begin
            state_q <= StReq;
            if (redirect) begin
              pc_q <= redirect_target;
            end else begin
              out_inst_q  <= hold_inst_q;
              out_pc_q    <= hold_pc_q;
              out_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign if_inst     = out_inst_q;
  assign if_pc       = out_pc_q;
  assign if_pc_plus4 = cur_pc_plus4;
  assign if_valid    = out_valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: randomized-latency memory, scripted and random
// consumer, and an architectural PC-stream scoreboard.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall_in;
  logic        branch_taken;
  logic [15:0] beq_offset;
  logic        jump;
  logic [25:0] jump_offset;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0000;

  always #5 clk = ~clk;

  inst_fetch_unit u_dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .stall_in     (stall_in),
    .branch_taken (branch_taken),
    .beq_offset   (beq_offset),
    .jump         (jump),
    .jump_offset  (jump_offset),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .if_pc_plus4  (if_pc_plus4),
    .if_valid     (if_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Memory contents: bijective in the address, so every PC has a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2001_0005;
  endfunction

  // ---------------- memory responder ----------------
  int          lat_min = 1;
  int          lat_max = 1;
  logic        busy;
  logic        was_busy;
  logic [31:0] pend_addr;
  int          cnt;
  logic        tgt_pend = 1'b0;
  logic [31:0] tgt_addr = '0;
  logic [31:0] req_log[$];

  initial begin
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    busy       = 1'b0;
    pend_addr  = '0;
    cnt        = 0;
    forever begin
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      if (rst) begin
        busy = 1'b0;
      end else begin
        was_busy = busy;
        if (busy) begin
          if (cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(pend_addr);
            busy       = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (imem_req) begin
          chk("one_outstanding", 32'(was_busy), 32'd0);
          chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
          if (tgt_pend) begin
            chk("redirect_addr", imem_addr, tgt_addr);
            tgt_pend = 1'b0;
          end
          req_log.push_back(imem_addr);
          busy      = 1'b1;
          pend_addr = imem_addr;
          cnt       = int'($urandom_range(lat_max, lat_min)) - 1;
        end
      end
    end
  end

  // ---------------- consumer driver ----------------
  int          mode = 0;        // 0: scripted/quiet, 1: random
  int          stall_pct = 0;
  logic        force_stall = 1'b0;
  logic        trig_en = 1'b0;
  logic        trig_fired = 1'b0;
  logic [31:0] trig_pc;
  logic        trig_jump;
  logic        trig_br;
  logic [25:0] trig_joff;
  logic [15:0] trig_boff;
  int          trig_wait;

  initial begin
    stall_in     = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    beq_offset   = '0;
    jump_offset  = '0;
    forever begin
      @(posedge clk);
      #1;
      stall_in     = 1'b0;
      branch_taken = 1'b0;
      jump         = 1'b0;
      beq_offset   = 16'($urandom);
      jump_offset  = 26'($urandom);
      if (mode == 1) begin
        stall_in     = ($urandom_range(99, 0) < stall_pct);
        jump         = ($urandom_range(9, 0) == 0);
        branch_taken = ($urandom_range(4, 0) == 0);
      end else if (force_stall) begin
        stall_in = 1'b1;
      end else if (trig_en && if_valid && if_pc == trig_pc) begin
        if (trig_wait > 0) begin
          stall_in = 1'b1;
          trig_wait--;
        end else begin
          jump         = trig_jump;
          branch_taken = trig_br;
          beq_offset   = trig_boff;
          jump_offset  = trig_joff;
          trig_en      = 1'b0;
          trig_fired   = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  // Expected architectural stream: start at the reset PC, then each consumed
  // instruction is followed by its redirect target or by the next sequential word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] nxt;
  logic        prev_hold = 1'b0;
  logic        prev_redirect = 1'b0;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;
  int          idle = 0;
  int          consumed = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_q.push_back('{pc: ResetPc, inst: mem_word(ResetPc)});
        prev_hold     = 1'b0;
        prev_redirect = 1'b0;
        idle          = 0;
      end else begin
        if (prev_hold) begin
          chk("stall_valid", 32'(if_valid), 32'd1);
          chk("stall_pc", if_pc, prev_pc);
          chk("stall_inst", if_inst, prev_inst);
        end
        if (prev_redirect) chk("squash_valid", 32'(if_valid), 32'd0);
        if (!if_valid) chk("nop_inst", if_inst, Nop);
        prev_redirect = 1'b0;
        if (if_valid && !stall_in) begin
          idle = 0;
          consumed++;
          if (exp_q.size() == 0) begin
            timeout_fail("scoreboard_empty");
          end else begin
            e = exp_q.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("if_inst", if_inst, e.inst);
            chk("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
            nxt = e.pc + 32'd4;
            if (jump) nxt = {nxt[31:28], jump_offset, 2'b00};
            else if (branch_taken) nxt = nxt + 32'(int'($signed(beq_offset)) * 4);
            if (jump || branch_taken) begin
              prev_redirect = 1'b1;
              tgt_pend      = 1'b1;
              tgt_addr      = nxt;
            end
            exp_q.push_back('{pc: nxt, inst: mem_word(nxt)});
          end
        end else begin
          idle++;
          if (idle == 200) begin
            timeout_fail("no_progress");
            idle = 0;
          end
        end
        prev_hold = if_valid && stall_in;
        prev_pc   = if_pc;
        prev_inst = if_inst;
      end
    end
  end

  // ---------------- helpers for the scripted part ----------------
  task automatic arm(input logic [31:0] pc, input logic j, input logic b,
                     input logic [25:0] joff, input logic [15:0] boff, input int w);
    trig_pc    = pc;
    trig_jump  = j;
    trig_br    = b;
    trig_joff  = joff;
    trig_boff  = boff;
    trig_wait  = w;
    trig_fired = 1'b0;
    trig_en    = 1'b1;
  endtask

  task automatic wait_fired(input string name, input int limit);
    int n = 0;
    while (!trig_fired && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!trig_fired) timeout_fail(name);
    trig_fired = 1'b0;
  endtask

  task automatic next_req_is(input string name, input logic [31:0] exp, input int limit);
    int base = req_log.size();
    int n = 0;
    while (req_log.size() <= base && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (req_log.size() > base) chk(name, req_log[base], exp);
    else timeout_fail(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_if_inst"}, if_inst, Nop);
    chk({tag, "_if_pc"}, if_pc, 32'd0);
    chk({tag, "_if_pc_plus4"}, if_pc_plus4, 32'd4);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, ResetPc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int snap;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    tgt_pend = 1'b1;
    tgt_addr = ResetPc;
    arm(32'h10, 1'b0, 1'b1, 26'h0, 16'hFFFC, 2);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // First fetch with 1-cycle memory.
    n = 0;
    while (!imem_valid && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!imem_valid) timeout_fail("first_response");
    @(posedge clk);
    #2;
    chk("first_valid", 32'(if_valid), 32'd1);
    chk("first_inst", if_inst, 32'h2001_0005);
    chk("first_pc", if_pc, 32'd0);
    n = 0;
    while (req_log.size() < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_log.size() >= 3) begin
      chk("seq_addr0", req_log[0], 32'h0);
      chk("seq_addr1", req_log[1], 32'h4);
      chk("seq_addr2", req_log[2], 32'h8);
    end else begin
      timeout_fail("seq_addr");
    end

    // Branch at 0x10 back by 4 words, taken out of HOLD.
    wait_fired("branch_fire", 100);
    next_req_is("branch_target", 32'h0000_0004, 20);

    // Jump into the last words below 0x1000_0000 so the stream crosses a region.
    arm(32'h14, 1'b1, 1'b0, 26'h3FF_FFF8, 16'h0, 2);

    // Long stall with a word buffered: no new request, nothing lost.
    n = 0;
    while (!if_valid && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    force_stall = 1'b1;
    repeat (3) @(negedge clk);
    snap = req_log.size();
    repeat (5) @(negedge clk);
    chk("stall_no_req", 32'(req_log.size() - snap), 32'd0);
    force_stall = 1'b0;
    lat_min = 4;
    lat_max = 4;

    // Jump redirect while waiting on a 4-cycle response.
    wait_fired("jump_fire", 200);
    next_req_is("jump_target", 32'h0FFF_FFE0, 40);

    // Jump and branch together at 0x1000_0020: jump wins.
    arm(32'h1000_0020, 1'b1, 1'b1, 26'h000_0040, 16'h0007, 0);
    wait_fired("jump_pri_fire", 600);
    next_req_is("jump_priority", 32'h1000_0100, 40);

    // Reset in the middle of a 4-cycle wait.
    n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("midwait_reset");
    tgt_pend = 1'b1;
    tgt_addr = ResetPc;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    next_req_is("restart_addr", ResetPc, 20);
    snap = consumed;
    n = 0;
    while (consumed < snap + 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (consumed < snap + 4) timeout_fail("restart_progress");

    // Random consumer against several memory latency profiles.
    for (int b = 0; b < 3; b++) begin
      lat_min   = (b == 1) ? 4 : 1;
      lat_max   = (b == 0) ? 1 : ((b == 1) ? 4 : 5);
      stall_pct = (b == 2) ? 50 : 30;
      mode      = 1;
      repeat (1500) @(negedge clk);
    end
    mode = 0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
